// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the register file: per-channel FIFOs for integer and FP
// writeback results, round-robin onto the single write port, plus pending-write masks.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_valid,
    output logic        int_ready,
    input  logic [4:0]  int_reg,
    input  logic [31:0] int_data,
    input  logic        fp_valid,
    output logic        fp_ready,
    input  logic [4:0]  fp_reg,
    input  logic        fp_double,
    input  logic [31:0] fp_data_0,
    input  logic [31:0] fp_data_1,
    output logic        RegWrite,
    output logic        Fp,
    output logic        double,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data_0,
    output logic [31:0] write_data_1,
    output logic [31:0] int_busy,
    output logic [31:0] fp_busy
);
    localparam int NCH   = 2;
    localparam int CH_FP = 1;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic        dbl;
        logic [31:0] data_0;
        logic [31:0] data_1;
    } wb_entry_t;

    wb_entry_t [NCH-1:0]            in_entry;
    wb_entry_t [NCH-1:0]            head;
    wb_entry_t [NCH-1:0][DEPTH-1:0] slots;
    logic      [NCH-1:0][DEPTH-1:0] slot_vld;
    logic      [NCH-1:0]            push, pop, full, empty;
    logic      [NCH-1:0][31:0]      busy_c;
    logic                           last_fp;
    logic                           grant_int, grant_fp;

    // Integer entries share the FP layout with dbl and the high word forced to 0.
    assign in_entry[0] = '{rd: int_reg, dbl: 1'b0, data_0: int_data, data_1: 32'd0};
    assign in_entry[1] = '{rd: fp_reg, dbl: fp_double, data_0: fp_data_0,
                           data_1: fp_double ? fp_data_1 : 32'd0};

    assign int_ready = rst_n & ~full[0];
    assign fp_ready  = rst_n & ~full[1];
    // $0 writes complete the handshake but never enter the queue.
    assign push[0]   = int_valid & int_ready & (int_reg != 5'd0);
    assign push[1]   = fp_valid & fp_ready;

    assign grant_int = ~empty[0] & (empty[1] | last_fp);
    assign grant_fp  = ~empty[1] & ~grant_int;
    assign pop       = {grant_fp, grant_int};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wb_entry_t [DEPTH-1:0] mem;
        logic [AW-1:0]         rd_ptr, wr_ptr;
        logic [AW:0]           count;

        assign full[c]  = (count == (AW+1)'(DEPTH));
        assign empty[c] = (count == '0);
        assign head[c]  = mem[rd_ptr];
        assign slots[c] = mem;

        for (genvar s = 0; s < DEPTH; s++) begin : g_slot
            assign slot_vld[c][s] = {1'b0, AW'(s) - rd_ptr} < count;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[c]) begin
                    mem[wr_ptr] <= in_entry[c];
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[c])
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push[c], pop[c]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_fp      <= 1'b1;
            RegWrite     <= 1'b0;
            Fp           <= 1'b0;
            double       <= 1'b0;
            write_reg    <= '0;
            write_data_0 <= '0;
            write_data_1 <= '0;
        end else if (grant_int || grant_fp) begin
            last_fp      <= grant_fp;
            RegWrite     <= 1'b1;
            Fp           <= grant_fp;
            double       <= head[grant_fp].dbl;
            write_reg    <= head[grant_fp].rd;
            write_data_0 <= head[grant_fp].data_0;
            write_data_1 <= head[grant_fp].data_1;
        end else begin
            RegWrite <= 1'b0;
            Fp       <= 1'b0;
            double   <= 1'b0;
        end
    end

    // A double marks its pair; the 5-bit add wraps r31 onto r0 like the register file.
    always_comb begin
        busy_c = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (slot_vld[c][s]) begin
                    busy_c[c][slots[c][s].rd] = 1'b1;
                    if (slots[c][s].dbl)
                        busy_c[c][slots[c][s].rd + 5'd1] = 1'b1;
                end
            end
        end
        if (RegWrite) begin
            busy_c[Fp][write_reg] = 1'b1;
            if (double)
                busy_c[Fp][write_reg + 5'd1] = 1'b1;
        end
    end

    assign int_busy = rst_n ? busy_c[0]     : 32'd0;
    assign fp_busy  = rst_n ? busy_c[CH_FP] : 32'd0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the two channels and the write port.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_valid, int_ready;
    logic [4:0]  int_reg;
    logic [31:0] int_data;
    logic        fp_valid, fp_ready;
    logic [4:0]  fp_reg;
    logic        fp_double;
    logic [31:0] fp_data_0, fp_data_1;
    logic        RegWrite, Fp, double;
    logic [4:0]  write_reg;
    logic [31:0] write_data_0, write_data_1, int_busy, fp_busy;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .int_valid(int_valid), .int_ready(int_ready), .int_reg(int_reg), .int_data(int_data),
        .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_reg(fp_reg), .fp_double(fp_double),
        .fp_data_0(fp_data_0), .fp_data_1(fp_data_1),
        .RegWrite(RegWrite), .Fp(Fp), .double(double), .write_reg(write_reg),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .int_busy(int_busy), .fp_busy(fp_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] d; } ient_t;
    typedef struct packed { logic [4:0] rd; logic dbl; logic [31:0] d0; logic [31:0] d1; } fent_t;

    // Reference model: two bounded queues, a last-winner flag, and the write-port register.
    ient_t       mq_int[$];
    fent_t       mq_fp[$];
    bit          m_last_fp;
    logic        m_rw, m_fp, m_dbl;
    logic [4:0]  m_wreg;
    logic [31:0] m_wd0, m_wd1;

    function automatic bit m_int_ready();
        return rst_n && (mq_int.size() < DEPTH);
    endfunction

    function automatic bit m_fp_ready();
        return rst_n && (mq_fp.size() < DEPTH);
    endfunction

    function automatic logic [31:0] m_int_busy();
        logic [31:0] b = '0;
        if (!rst_n) return '0;
        foreach (mq_int[i]) b[mq_int[i].rd] = 1'b1;
        if (m_rw && !m_fp) b[m_wreg] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_fp_busy();
        logic [31:0] b = '0;
        logic [4:0]  r1;
        if (!rst_n) return '0;
        foreach (mq_fp[i]) begin
            b[mq_fp[i].rd] = 1'b1;
            r1 = mq_fp[i].rd + 5'd1;
            if (mq_fp[i].dbl) b[r1] = 1'b1;
        end
        if (m_rw && m_fp) begin
            b[m_wreg] = 1'b1;
            r1 = m_wreg + 5'd1;
            if (m_dbl) b[r1] = 1'b1;
        end
        return b;
    endfunction

    // Advance the model by one edge using the inputs currently driven, then clock the DUT.
    task automatic cycle();
        bit ia, fa, gi, gf;
        ient_t ie;
        fent_t fe;
        if (!rst_n) begin
            mq_int.delete(); mq_fp.delete();
            m_last_fp = 1'b1; m_rw = 0; m_fp = 0; m_dbl = 0;
            m_wreg = '0; m_wd0 = '0; m_wd1 = '0;
        end else begin
            ia = int_valid && m_int_ready();
            fa = fp_valid && m_fp_ready();
            gi = (mq_int.size() > 0) && ((mq_fp.size() == 0) || m_last_fp);
            gf = (mq_fp.size() > 0) && !gi;
            if (gi) begin
                ie = mq_int.pop_front();
                m_rw = 1; m_fp = 0; m_dbl = 0; m_wreg = ie.rd; m_wd0 = ie.d; m_wd1 = '0; m_last_fp = 0;
            end else if (gf) begin
                fe = mq_fp.pop_front();
                m_rw = 1; m_fp = 1; m_dbl = fe.dbl; m_wreg = fe.rd; m_wd0 = fe.d0; m_wd1 = fe.d1; m_last_fp = 1;
            end else begin
                m_rw = 0; m_fp = 0; m_dbl = 0;
            end
            if (ia && int_reg != 5'd0) mq_int.push_back('{int_reg, int_data});
            if (fa) mq_fp.push_back('{fp_reg, fp_double, fp_data_0, fp_double ? fp_data_1 : 32'd0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int_valid = 0; fp_valid = 0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rst_n = 0; int_valid = 1; int_reg = 5'd5; int_data = 32'h1234; fp_valid = 1;
        fp_reg = 5'd2; fp_double = 0; fp_data_0 = 32'h55; fp_data_1 = 32'h66;
        repeat (2) cycle();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        checks++; if ({int_ready, fp_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {int_ready, fp_ready}); end
        checks++; if ({int_busy, fp_busy} !== 64'd0) begin errors++; $display("FAIL reset_busy: got %h/%h want 0", int_busy, fp_busy); end
        checks++; if ({Fp, double, write_reg, write_data_0, write_data_1} !== 71'd0) begin
            errors++; $display("FAIL reset_outputs: got Fp=%b dbl=%b reg=%0d d0=%h d1=%h want 0", Fp, double, write_reg, write_data_0, write_data_1); end
        rst_n = 1; int_valid = 0; fp_valid = 0;
        cycle();
        int_valid = 1; int_reg = 5'd5; int_data = 32'hDEADBEEF;
        checks++; if (int_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b want 1", int_ready); end
        cycle();
        int_valid = 0;
        checks++; if (RegWrite !== 1'b0 || int_busy !== 32'h20) begin
            errors++; $display("FAIL first_pending: got rw=%b busy=%h want rw=0 busy=00000020", RegWrite, int_busy); end
        cycle();
        checks++; if ({RegWrite, Fp, write_reg, write_data_0} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF} || int_busy !== 32'h20) begin
            errors++; $display("FAIL first_issue: got rw=%b fp=%b reg=%0d d0=%h busy=%h want 1 0 5 deadbeef 00000020",
                               RegWrite, Fp, write_reg, write_data_0, int_busy); end
        cycle();
        checks++; if (RegWrite !== 1'b0 || int_busy !== 32'd0) begin
            errors++; $display("FAIL first_done: got rw=%b busy=%h want 0 0", RegWrite, int_busy); end
    endtask

    task automatic test_zero_drop();
        int_valid = 1; int_reg = 5'd0; int_data = 32'h1;
        checks++; if (int_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", int_ready); end
        cycle();
        int_valid = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (RegWrite !== 1'b0 || int_busy !== 32'd0) begin
                errors++; $display("FAIL zero_drop c%0d: got rw=%b busy=%h want 0 0", i, RegWrite, int_busy); end
            cycle();
        end
    endtask

    task automatic test_double_wrap();
        fp_valid = 1; fp_reg = 5'd31; fp_double = 1; fp_data_0 = 32'h11111111; fp_data_1 = 32'h22222222;
        cycle();
        fp_valid = 0;
        checks++; if (fp_busy !== 32'h80000001 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL wrap_pending: got busy=%h rw=%b want 80000001 0", fp_busy, RegWrite); end
        cycle();
        checks++; if ({RegWrite, Fp, double, write_reg} !== {3'b111, 5'd31} ||
                      {write_data_0, write_data_1} !== {32'h11111111, 32'h22222222}) begin
            errors++; $display("FAIL wrap_issue: got rw=%b fp=%b dbl=%b reg=%0d d=%h_%h want 1 1 1 31 11111111_22222222",
                               RegWrite, Fp, double, write_reg, write_data_0, write_data_1); end
        checks++; if (fp_busy !== 32'h80000001 || int_busy !== 32'd0) begin
            errors++; $display("FAIL wrap_busy: got fp=%h int=%h want 80000001 0", fp_busy, int_busy); end
        cycle();
        checks++; if (fp_busy !== 32'd0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL wrap_done: got busy=%h rw=%b want 0 0", fp_busy, RegWrite); end
    endtask

    // Last grant went to FP (previous test), so the first tie goes to integer.
    task automatic test_contention();
        ient_t iv[4];
        fent_t fv[4];
        bit iss_fp[16];
        logic [31:0] iss_d[16];
        int ii = 0, fi = 0, n = 0;
        bit ia, fa;
        idle(3);
        for (int k = 0; k < 4; k++) begin
            iv[k] = '{5'($urandom_range(1, 31)), $urandom};
            fv[k] = '{5'($urandom_range(0, 31)), 1'b0, $urandom, 32'd0};
        end
        for (int c = 0; c < 30; c++) begin
            int_valid = (ii < 4); fp_valid = (fi < 4);
            if (ii < 4) begin int_reg = iv[ii].rd; int_data = iv[ii].d; end
            if (fi < 4) begin fp_reg = fv[fi].rd; fp_double = 0; fp_data_0 = fv[fi].d0; fp_data_1 = 32'd0; end
            ia = int_valid && int_ready;
            fa = fp_valid && fp_ready;
            cycle();
            if (ia) ii++;
            if (fa) fi++;
            if (RegWrite) begin
                if (n < 16) begin iss_fp[n] = Fp; iss_d[n] = write_data_0; end
                n++;
            end
        end
        int_valid = 0; fp_valid = 0;
        checks++; if (n != 8) begin errors++; $display("FAIL contention_count: got %0d writes want 8", n); end
        for (int k = 0; k < 8 && k < n; k++) begin
            checks++;
            if (iss_fp[k] !== 1'(k % 2) || iss_d[k] !== ((k % 2) ? fv[k/2].d0 : iv[k/2].d)) begin
                errors++; $display("FAIL contention_order #%0d: got fp=%b d=%h want fp=%0d d=%h",
                                   k, iss_fp[k], iss_d[k], k % 2, (k % 2) ? fv[k/2].d0 : iv[k/2].d); end
        end
    endtask

    task automatic test_backpressure();
        int fi = 0, fp_iss = 0;
        bit saw_full = 0, saw_resume = 0, fa;
        idle(3);
        for (int c = 0; c < 40; c++) begin
            int_valid = (c < 24); int_reg = 5'($urandom_range(1, 31)); int_data = $urandom;
            fp_valid = (fi < DEPTH + 2);
            if (fp_valid) begin fp_reg = 5'(2 * fi); fp_double = 1; fp_data_0 = 32'hF000 + fi; fp_data_1 = 32'hE000 + fi; end
            checks++; if (fp_ready !== m_fp_ready() || int_ready !== m_int_ready()) begin
                errors++; $display("FAIL bp_ready c%0d: got int=%b fp=%b want %b %b", c, int_ready, fp_ready, m_int_ready(), m_fp_ready()); end
            if (fp_valid && !fp_ready) saw_full = 1;
            fa = fp_valid && fp_ready;
            if (fa && saw_full) saw_resume = 1;
            cycle();
            if (fa) fi++;
            if (RegWrite && Fp) fp_iss++;
            checks++; if ({RegWrite, Fp, double, write_reg, write_data_0, write_data_1} !== {m_rw, m_fp, m_dbl, m_wreg, m_wd0, m_wd1}) begin
                errors++; $display("FAIL bp_port c%0d: got %b%b%b r%0d %h %h want %b%b%b r%0d %h %h", c, RegWrite, Fp, double,
                                   write_reg, write_data_0, write_data_1, m_rw, m_fp, m_dbl, m_wreg, m_wd0, m_wd1); end
        end
        checks++; if (fp_iss != DEPTH + 2) begin errors++; $display("FAIL bp_fp_writes: got %0d want %0d", fp_iss, DEPTH + 2); end
        checks++; if (!(saw_full && saw_resume)) begin errors++; $display("FAIL bp_stall: got full=%b resume=%b want 1 1", saw_full, saw_resume); end
    endtask

    task automatic test_back_to_back();
        idle(4);
        int_valid = 1; int_reg = 5'd7; int_data = 32'hAAAA0001;
        cycle();
        int_data = 32'hBBBB0002;
        checks++; if (int_busy[7] !== 1'b1 || int_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got busy7=%b ready=%b want 1 1", int_busy[7], int_ready); end
        cycle();
        int_valid = 0;
        checks++; if (RegWrite !== 1'b1 || write_data_0 !== 32'hAAAA0001 || int_busy[7] !== 1'b1) begin
            errors++; $display("FAIL b2b_a: got rw=%b d=%h busy7=%b want 1 aaaa0001 1", RegWrite, write_data_0, int_busy[7]); end
        cycle();
        checks++; if (RegWrite !== 1'b1 || write_data_0 !== 32'hBBBB0002 || int_busy[7] !== 1'b1) begin
            errors++; $display("FAIL b2b_b: got rw=%b d=%h busy7=%b want 1 bbbb0002 1", RegWrite, write_data_0, int_busy[7]); end
        cycle();
        checks++; if (RegWrite !== 1'b0 || int_busy[7] !== 1'b0) begin
            errors++; $display("FAIL b2b_done: got rw=%b busy7=%b want 0 0", RegWrite, int_busy[7]); end
    endtask

    task automatic test_random();
        bit int_stall = 0, fp_stall = 0;
        for (int c = 0; c < 400; c++) begin
            rst_n = !(c >= 200 && c < 202);
            if (!int_stall) begin
                int_valid = ($urandom_range(0, 3) != 0); int_reg = 5'($urandom_range(0, 31)); int_data = $urandom;
            end
            if (!fp_stall) begin
                fp_valid = ($urandom_range(0, 2) != 0); fp_reg = 5'($urandom_range(0, 31));
                fp_double = 1'($urandom); fp_data_0 = $urandom; fp_data_1 = $urandom;
            end
            int_stall = int_valid && !int_ready && rst_n;
            fp_stall  = fp_valid && !fp_ready && rst_n;
            cycle();
            checks++; if ({int_ready, fp_ready} !== {m_int_ready(), m_fp_ready()}) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, int_ready, fp_ready, m_int_ready(), m_fp_ready()); end
            checks++; if ({RegWrite, Fp, double, write_reg, write_data_0, write_data_1} !== {m_rw, m_fp, m_dbl, m_wreg, m_wd0, m_wd1}) begin
                errors++; $display("FAIL rnd_port c%0d: got %b%b%b r%0d %h %h want %b%b%b r%0d %h %h", c, RegWrite, Fp, double,
                                   write_reg, write_data_0, write_data_1, m_rw, m_fp, m_dbl, m_wreg, m_wd0, m_wd1); end
            checks++; if (int_busy !== m_int_busy() || fp_busy !== m_fp_busy()) begin
                errors++; $display("FAIL rnd_busy c%0d: got %h/%h want %h/%h", c, int_busy, fp_busy, m_int_busy(), m_fp_busy()); end
        end
        rst_n = 1;
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; int_valid = 0; fp_valid = 0; int_reg = '0; int_data = '0;
        fp_reg = '0; fp_double = 0; fp_data_0 = '0; fp_data_1 = '0;
        @(posedge clk); #1;
        test_reset();
        test_zero_drop();
        test_double_wrap();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end of the integer/FP register file in the single-cycle MIPS core. It accepts writeback results from two producers over valid/ready channels: the integer channel (ALU/mult-div) and the FP channel (FPU, lwc1/ldc1). Each channel is buffered in its own FIFO. The block arbitrates round-robin onto the register file's single write port (RegWrite, Fp, double, write_reg, write_data_0/1). It also exports per-register pending-write masks that the hazard/stall logic uses.

## Interface
- DEPTH, 2, entries per channel FIFO; power of two, ≥2
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- int_valid  in  1  integer result offered
- int_ready  out  1  integer FIFO can accept
- int_reg  in  5  integer destination register
- int_data  in  32  integer result
- fp_valid  in  1  FP result offered
- fp_ready  out  1  FP FIFO can accept
- fp_reg  in  5  FP destination register (even register for doubles)
- fp_double  in  1  64-bit result; writes pair fp_reg, fp_reg+1
- fp_data_0  in  32  FP low word → fp_reg
- fp_data_1  in  32  FP high word → fp_reg+1; ignored when fp_double=0
- RegWrite  out  1  write strobe to register file
- Fp  out  1  1 = FP bank, 0 = integer bank
- double  out  1  pair write (drives register file `double`; its `fmt0` is tied 0)
- write_reg  out  5  destination register
- write_data_0  out  32  first word
- write_data_1  out  32  second word
- int_busy  out  32  bit r set = write to integer r queued or issuing
- fp_busy  out  32  bit r set = write to FP r queued or issuing

## Operation
- Accept: transfer occurs on an edge where valid & ready are both high. Entry = {reg, data} (int) or {reg, double, data_0, data_1} (FP). ready = FIFO count < DEPTH.
- Integer writes to register 0 are accepted (handshake completes) but discarded: no enqueue, no busy bit. The register file does not hardwire $0, so this block protects it.
- Arbitration, once per cycle over the FIFO heads:
  - only one head valid → grant it;
  - both heads valid → grant the channel not granted last; last_grant resets to FP, so integer wins the first tie;
  - last_grant updates only on a grant.
- Issue: the granted head is popped and loaded into the output register on the same edge.
  - RegWrite=1; Fp = 1 for the FP channel; double = entry double (0 for int); write_reg/write_data_0/write_data_1 from the entry (write_data_1 = 0 for int).
  - No grant → RegWrite=0, Fp=0, double=0; write_reg and write_data hold their previous values.
- Busy masks are combinational over all valid FIFO entries plus the output register while RegWrite=1.
  - FP double sets fp_busy[r] and fp_busy[(r+1) mod 32]; r=31 wraps to 0, matching the register file's 5-bit add.
  - Duplicate destinations in flight stay busy until the last one issues.
- Simultaneous accept and pop on a full FIFO: ready is computed from the pre-edge count, so a full FIFO does not accept that cycle. No same-cycle pass-through.
- Order is preserved within each channel. No ordering guarantee across channels.

## Timing
- Reset (rst_n low at an edge): FIFOs empty, last_grant=FP, RegWrite=0, Fp=0, double=0, write_reg=0, write_data_0/1=0. While rst_n is low, int_ready=fp_ready=0, inputs are ignored, and busy masks are 0. Reset mid-stream discards all queued entries.
- Latency: accepted at edge k → earliest RegWrite=1 in the cycle after edge k+1 → register file commits at edge k+2. Busy is set from the cycle after edge k until edge k+2.
- Throughput: one register-file write per cycle. Two saturated channels alternate int, FP, int, …
- ready depends only on registered state, never on valid.
- valid may drop without a transfer; the producer must hold entry fields stable while valid & !ready.

## Test plan
- Reset: drive rst_n low with int_valid=1 → RegWrite=0, int_ready=0, int_busy=0. After release, first accept of int_reg=5, data=0xDEADBEEF → RegWrite=1, Fp=0, write_reg=5 exactly 2 edges later; int_busy[5]=1 during the intervening cycles.
- $0 drop: int_reg=0, data=0x1 → handshake completes; RegWrite stays 0 for 4 cycles; int_busy stays 0.
- Double wrap: fp_reg=31, fp_double=1, data 0x11111111/0x22222222 → RegWrite=1, Fp=1, double=1, write_reg=31; fp_busy bits 31 and 0 set until commit.
- Contention: both channels continuously valid with 4 entries each → issue order int, FP, int, FP, …; per-channel data order preserved; no entry lost.
- Backpressure: hold fp_valid for DEPTH+2 cycles while integer traffic saturates → fp_ready=0 when the FIFO is full; resumes accepting after a pop; no overflow and no duplicate writes.
- Same destination twice: two int writes to r7 back-to-back → int_busy[7] stays 1 until the second write commits; write order is data A then data B.
